// File: rtl/sistema_y_pkg.sv
// sistema_y_pkg: shared state encoding and default streak/alarm thresholds
package sistema_y_pkg;
   typedef enum logic [1:0] {IDLE, CUENTA, ABIERTO, ALARMA} estado_t;
   localparam int RACHA_N_DEF = 3;
   localparam int MAX_ERR_DEF = 4;
endpackage

// File: rtl/sistema_y.sv
// sistema_y: 4-bit equality comparator whose E flag feeds validador_racha
module sistema_y (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       e
);
   assign e = (a == b);
endmodule

// File: rtl/validador_racha_contador_sat.sv
// contador_sat: saturating up-counter with synchronous clear; never wraps past MAX
module contador_sat #(
   parameter int WIDTH = 2,
   parameter int MAX   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   logic [WIDTH-1:0] q_d, q_q;
   always_comb q_d = clr ? '0 : (inc && q_q != MAX_V) ? q_q + 1'b1 : q_q;
   always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
   assign q = q_q;
endmodule

// File: rtl/validador_racha.sv
// validador_racha: opens after RACHA_N consecutive valid matches, latches alarm after MAX_ERR mismatches
module validador_racha
   import sistema_y_pkg::*;
#(
   parameter int RACHA_N = RACHA_N_DEF,
   parameter int MAX_ERR = MAX_ERR_DEF,
   parameter int CW      = $clog2(RACHA_N + 1),
   parameter int EW      = $clog2(MAX_ERR + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_in,
   input  logic          eq_in,
   input  logic          clear,
   output logic [CW-1:0] racha,
   output logic [EW-1:0] errores,
   output logic          ok,
   output logic          abierto,
   output logic          alarma
);
   localparam logic [CW-1:0] R_LAST = CW'(RACHA_N - 1);
   localparam logic [EW-1:0] E_LAST = EW'(MAX_ERR - 1);
   estado_t estado_d, estado_q;
   logic ok_d, ok_q;
   logic r_inc, r_clr, e_inc, e_clr;
   contador_sat #(.WIDTH(CW), .MAX(RACHA_N)) u_racha (
      .clk(clk), .rst(rst), .clr(r_clr), .inc(r_inc), .q(racha)
   );
   contador_sat #(.WIDTH(EW), .MAX(MAX_ERR)) u_errores (
      .clk(clk), .rst(rst), .clr(e_clr), .inc(e_inc), .q(errores)
   );
   // Samples only count while still collecting; open/alarm states ignore them until clear
   always_comb begin
      estado_d = estado_q;
      ok_d     = 1'b0;
      r_inc    = 1'b0;
      r_clr    = 1'b0;
      e_inc    = 1'b0;
      e_clr    = 1'b0;
      if (clear) begin
         estado_d = IDLE;
         r_clr    = 1'b1;
         e_clr    = 1'b1;
      end else if (valid_in && (estado_q == IDLE || estado_q == CUENTA)) begin
         if (eq_in) begin
            r_inc = 1'b1;
            if (racha == R_LAST) begin
               estado_d = ABIERTO;
               ok_d     = 1'b1;
               e_clr    = 1'b1;
            end else begin
               estado_d = CUENTA;
            end
         end else begin
            r_clr    = 1'b1;
            e_inc    = 1'b1;
            estado_d = (errores == E_LAST) ? ALARMA : IDLE;
         end
      end
   end
   always_ff @(posedge clk) begin
      estado_q <= rst ? IDLE : estado_d;
      ok_q     <= rst ? 1'b0 : ok_d;
   end
   assign ok      = ok_q;
   assign abierto = (estado_q == ABIERTO);
   assign alarma  = (estado_q == ALARMA);
endmodule

// File: tb/tb_validador_racha.sv
// tb_validador_racha: directed scenarios for validador_racha fed through sistema_y
module tb_validador_racha;
   import sistema_y_pkg::*;
   logic       clk = 1'b0;
   logic       rst, valid_in, clear;
   logic [3:0] a, b;
   logic       eq;
   logic [1:0] racha;
   logic [2:0] errores;
   logic       ok, abierto, alarma;
   logic [7:0] obs;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sistema_y u_cmp (.a(a), .b(b), .e(eq));

   validador_racha dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .eq_in(eq), .clear(clear),
      .racha(racha), .errores(errores), .ok(ok), .abierto(abierto), .alarma(alarma)
   );

   assign obs = {racha, errores, ok, abierto, alarma};

   function automatic logic [7:0] ex(input int r, input int e, input logic o, input logic ab, input logic al);
      logic [1:0] rr;
      logic [2:0] ee;
      rr = r[1:0];
      ee = e[2:0];
      return {rr, ee, o, ab, al};
   endfunction

   // s = {rst, clear, valid_in, match}; a mismatch drives different operands into sistema_y
   task automatic drive(input logic [3:0] s);
      {rst, clear, valid_in} = s[3:1];
      a = 4'hA;
      b = s[0] ? 4'hA : 4'h5;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [3:0] st [2];
      logic [7:0] xp [2];
      st = '{4'b1011, 4'b1011};
      xp = '{ex(0,0,0,0,0), ex(0,0,0,0,0)};
      for (int i = 0; i < 2; i++) begin
         drive(st[i]);
         checks++;
         if (obs !== xp[i]) begin
            errors++;
            $display("FAIL reset[%0d] got %b want %b", i, obs, xp[i]);
         end
      end
   endtask

   task automatic test_streak;
      logic [3:0] st [6];
      logic [7:0] xp [6];
      st = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0100};
      xp = '{ex(1,0,0,0,0), ex(2,0,0,0,0), ex(3,0,1,1,0),
             ex(3,0,0,1,0), ex(3,0,0,1,0), ex(0,0,0,0,0)};
      for (int i = 0; i < 6; i++) begin
         drive(st[i]);
         checks++;
         if (obs !== xp[i]) begin
            errors++;
            $display("FAIL streak[%0d] got %b want %b", i, obs, xp[i]);
         end
      end
   endtask

   task automatic test_broken;
      logic [3:0] st [7];
      logic [7:0] xp [7];
      st = '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0100};
      xp = '{ex(1,0,0,0,0), ex(2,0,0,0,0), ex(0,1,0,0,0), ex(1,1,0,0,0),
             ex(2,1,0,0,0), ex(3,0,1,1,0), ex(0,0,0,0,0)};
      for (int i = 0; i < 7; i++) begin
         drive(st[i]);
         checks++;
         if (obs !== xp[i]) begin
            errors++;
            $display("FAIL broken[%0d] got %b want %b", i, obs, xp[i]);
         end
      end
   endtask

   task automatic test_alarm;
      logic [3:0] st [6];
      logic [7:0] xp [6];
      st = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0100};
      xp = '{ex(0,1,0,0,0), ex(0,2,0,0,0), ex(0,3,0,0,0),
             ex(0,4,0,0,1), ex(0,4,0,0,1), ex(0,0,0,0,0)};
      for (int i = 0; i < 6; i++) begin
         drive(st[i]);
         checks++;
         if (obs !== xp[i]) begin
            errors++;
            $display("FAIL alarm[%0d] got %b want %b", i, obs, xp[i]);
         end
      end
   endtask

   task automatic test_gap;
      logic [3:0] st [7];
      logic [7:0] xp [7];
      st = '{4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0011, 4'b0111, 4'b0011};
      xp = '{ex(1,0,0,0,0), ex(1,0,0,0,0), ex(1,0,0,0,0), ex(1,0,0,0,0),
             ex(2,0,0,0,0), ex(0,0,0,0,0), ex(1,0,0,0,0)};
      for (int i = 0; i < 7; i++) begin
         drive(st[i]);
         checks++;
         if (obs !== xp[i]) begin
            errors++;
            $display("FAIL gap[%0d] got %b want %b", i, obs, xp[i]);
         end
      end
      drive(4'b0100);
   endtask

   task automatic test_rst_mid;
      logic [3:0] st [7];
      logic [7:0] xp [7];
      st = '{4'b0011, 4'b0010, 4'b0011, 4'b1011, 4'b0011, 4'b0011, 4'b0011};
      xp = '{ex(1,0,0,0,0), ex(0,1,0,0,0), ex(1,1,0,0,0), ex(0,0,0,0,0),
             ex(1,0,0,0,0), ex(2,0,0,0,0), ex(3,0,1,1,0)};
      for (int i = 0; i < 7; i++) begin
         drive(st[i]);
         checks++;
         if (obs !== xp[i]) begin
            errors++;
            $display("FAIL rst_mid[%0d] got %b want %b", i, obs, xp[i]);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      clear    = 1'b0;
      valid_in = 1'b0;
      a        = 4'h0;
      b        = 4'h0;
      test_reset();
      test_streak();
      test_broken();
      test_alarm();
      test_gap();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
